boids_frame_sequencer: RTL

- Initiator side of the single-boid updater handshake; owns the live boid attribute array.
- Per frame, walks boid indices 0..NUM_OF_BOIDS-1. For each index it drives `current_boids_num`, pulses `upd_enable` and waits for the updater's `finish` handshake.
- Captures the updated pos/vel of each boid into a shadow array, then commits shadow to live atomically at frame end.
- Also provides seeding writes and a combinational read port for the pixel drawer.

---
 rtl/boids_frame_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/boids_frame_sequencer.sv
// Frame sequencer for the single-boid updater: walks every boid once per frame, captures
// results into a shadow array and commits shadow to the live array atomically at frame end.
module boids_frame_sequencer #(
    parameter int unsigned NUM_OF_BOIDS   = 10,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               frame_start,
    input  logic                               wr_en,
    input  logic [12:0]                        wr_index,
    input  logic [1:0]                         wr_sel,
    input  logic [26:0]                        wr_data,
    input  logic [12:0]                        rd_index,
    output logic [26:0]                        rd_x,
    output logic [26:0]                        rd_y,
    output logic [NUM_OF_BOIDS*4-1:0][26:0]    boids_attr_array,
    output logic [12:0]                        current_boids_num,
    output logic                               upd_enable,
    input  logic                               upd_finish,
    input  logic [26:0]                        upd_pos_x,
    input  logic [26:0]                        upd_pos_y,
    input  logic [26:0]                        upd_vel_x,
    input  logic [26:0]                        upd_vel_y,
    output logic                               busy,
    output logic                               frame_done,
    output logic                               timeout_err,
    output logic                               overrun
);

    localparam int unsigned NumFields = NUM_OF_BOIDS * 4;
    localparam int unsigned FieldW    = $clog2(NumFields);
    localparam int unsigned CntW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [12:0] NumBoids  = 13'(NUM_OF_BOIDS);
    localparam logic [12:0] LastIdx   = 13'(NUM_OF_BOIDS - 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StPrime, StIdle, StIssue, StWaitLow, StWaitHigh, StCapture, StNext, StCommit
    } state_e;

    state_e            state_q, state_d;
    logic [26:0]       live_q   [NumFields];
    logic [26:0]       live_d   [NumFields];
    logic [26:0]       shadow_q [NumFields];
    logic [26:0]       shadow_d [NumFields];
    logic [12:0]       idx_q, idx_d;
    logic [12:0]       cur_q, cur_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;
    logic              upd_enable_q, upd_enable_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    logic              wr_ok;
    logic [FieldW-1:0] wr_field;
    logic [FieldW-1:0] cap_base;
    logic [FieldW-1:0] rd_field;

    always_comb begin
        state_d      = state_q;
        live_d       = live_q;
        shadow_d     = shadow_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        overrun_d    = overrun_q;
        timeout_d    = timeout_q;

        wr_ok    = wr_en && (state_q == StIdle || state_q == StPrime) && (wr_index < NumBoids);
        wr_field = {wr_index[FieldW-3:0], wr_sel};
        cap_base = {idx_q[FieldW-3:0], 2'b00};

        // Seed write is applied first so a same-cycle frame_start copies the new value.
        if (wr_ok) begin
            live_d[wr_field]   = wr_data;
            shadow_d[wr_field] = wr_data;
        end

        if (frame_start && state_q != StIdle) begin
            pending_d = 1'b1;
            if (pending_q) overrun_d = 1'b1;
        end

        unique case (state_q)
            StPrime: if (upd_finish) state_d = StIdle;
            StIdle: begin
                if (frame_start || pending_q) begin
                    pending_d = 1'b0;
                    idx_d     = '0;
                    shadow_d  = live_d;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWaitLow;
            end
            StWaitLow: begin
                if (!upd_finish) begin
                    cnt_d   = '0;
                    state_d = StWaitHigh;
                end else if (cnt_q == CntMax) begin
                    timeout_d = 1'b1;
                    state_d   = StNext;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitHigh: begin
                if (upd_finish) begin
                    state_d = StCapture;
                end else if (cnt_q == CntMax) begin
                    timeout_d = 1'b1;
                    state_d   = StNext;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StCapture: begin
                shadow_d[cap_base]         = upd_pos_x;
                shadow_d[cap_base | 'd1]   = upd_pos_y;
                shadow_d[cap_base | 'd2]   = upd_vel_x;
                shadow_d[cap_base | 'd3]   = upd_vel_y;
                state_d                    = StNext;
            end
            StNext: begin
                if (idx_q == LastIdx) begin
                    state_d = StCommit;
                end else begin
                    idx_d   = idx_q + 13'd1;
                    state_d = StIssue;
                end
            end
            StCommit: begin
                live_d  = shadow_q;
                state_d = StIdle;
            end
            default: state_d = StPrime;
        endcase

        cur_d        = (state_d == StIssue) ? idx_d : cur_q;
        upd_enable_d = (state_d == StIssue);
        busy_d       = !(state_d == StIdle || state_d == StPrime);
        frame_done_d = (state_q == StCommit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StPrime;
            live_q       <= '{default: '0};
            shadow_q     <= '{default: '0};
            idx_q        <= '0;
            cur_q        <= '0;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            upd_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            live_q       <= live_d;
            shadow_q     <= shadow_d;
            idx_q        <= idx_d;
            cur_q        <= cur_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
            upd_enable_q <= upd_enable_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        rd_field = {rd_index[FieldW-3:0], 2'b00};
        rd_x     = '0;
        rd_y     = '0;
        if (rd_index < NumBoids) begin
            rd_x = live_q[rd_field];
            rd_y = live_q[rd_field | 'd1];
        end
    end

    always_comb begin
        for (int i = 0; i < NumFields; i++) begin
            boids_attr_array[i] = live_q[i];
        end
    end

    assign current_boids_num = cur_q;
    assign upd_enable        = upd_enable_q;
    assign busy              = busy_q;
    assign frame_done        = frame_done_q;
    assign timeout_err       = timeout_q;
    assign overrun           = overrun_q;

endmodule
